// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM
// state encoding and the op decode helpers.
package ex_muldiv_pkg;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_MULW   = 4'd8;
    localparam logic [3:0] OP_DIVW   = 4'd9;
    localparam logic [3:0] OP_DIVUW  = 4'd10;
    localparam logic [3:0] OP_REMW   = 4'd11;
    localparam logic [3:0] OP_REMUW  = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_w(input logic [3:0] op);
        return op >= OP_MULW;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_high(input logic [3:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_signed_rs1(input logic [3:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_signed_rs2(input logic [3:0] op);
        return op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// cycle for n_i cycles. done_o is high during the final iteration.
module muldiv_div_core #(
    parameter int XLEN = 64,
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [CW-1:0]   n_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic            ge;

    assign trial = {rem_q, quo_q[XLEN-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign ge    = ~diff[XLEN];

    always_comb begin
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (kill_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            // Short (W) dividends are pre-aligned so their MSB is consumed first.
            quo_d = dividend_i << (CW'(XLEN) - n_i);
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = n_i;
        end else if (cnt_q != '0) begin
            rem_d = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ge};
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign quot_o = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative RISC-V M-extension unit with pipeline stall request.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            ex_stall_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              consumed_q, consumed_d;
    logic [3:0]        op_q, op_d;
    logic              res_neg_q, res_neg_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;

    logic              w_in, sgn_a, sgn_b, a_neg, b_neg, div0, ovf, accept;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic [CW-1:0]     n_in;
    logic              div_start, div_done;
    logic [XLEN-1:0]   div_quot, div_rem;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step, prod_adj, prod_s;
    logic [XLEN-1:0]   div_mag, div_res, raw_res;

    assign w_in  = is_w(op_i);
    assign sgn_a = is_signed_rs1(op_i);
    assign sgn_b = is_signed_rs2(op_i);
    assign a_ext = w_in ? ext32(rs1_i, sgn_a) : rs1_i;
    assign b_ext = w_in ? ext32(rs2_i, sgn_b) : rs2_i;
    assign a_neg = sgn_a & a_ext[XLEN-1];
    assign b_neg = sgn_b & b_ext[XLEN-1];
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;
    assign n_in  = w_in ? CW'(32) : CW'(XLEN);
    assign div0  = (b_ext == '0);
    assign ovf   = sgn_b & (b_ext == '1) &
                   (w_in ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == XMIN));

    // A held instruction must not be re-issued the cycle after it completed.
    assign accept = (state_q == ST_IDLE) & valid_i & ~flush_i & ~consumed_q;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{prod_q[0]}} & mcand_q};
    assign prod_step = {mul_sum, prod_q[XLEN-1:1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        consumed_d = 1'b0;
        op_d       = op_q;
        res_neg_d  = res_neg_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        div_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = op_i;
                    special_d = 1'b0;
                    mcand_d   = a_mag;
                    if (is_div(op_i)) begin
                        res_neg_d = is_rem(op_i) ? a_neg : (a_neg ^ b_neg);
                        if (div0) begin
                            special_d  = 1'b1;
                            spec_res_d = is_rem(op_i) ? a_ext : '1;
                            state_d    = ST_DONE;
                        end else if (ovf) begin
                            special_d  = 1'b1;
                            spec_res_d = is_rem(op_i) ? '0 : a_ext;
                            state_d    = ST_DONE;
                        end else begin
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                        end
                    end else begin
                        res_neg_d = a_neg ^ b_neg;
`ifdef MULDIV_FAST_MUL_EN
                        prod_d  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
                        state_d = ST_DONE;
`else
                        prod_d  = {{XLEN{1'b0}}, b_mag};
                        cnt_d   = n_in;
                        state_d = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_DONE;
            end
            ST_DIV: begin
                if (div_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!ex_stall_i) begin
                    state_d    = ST_IDLE;
                    consumed_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d    = ST_IDLE;
            consumed_d = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            consumed_q <= 1'b0;
            op_q       <= OP_MUL;
            res_neg_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            consumed_q <= consumed_d;
            op_q       <= op_d;
            res_neg_q  <= res_neg_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
        end
    end

    muldiv_div_core #(
        .XLEN (XLEN),
        .CW   (CW)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .kill_i     (flush_i),
        .n_i        (n_in),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // A 32-step shift-add leaves the product 32 bits above its natural position.
`ifdef MULDIV_FAST_MUL_EN
    assign prod_adj = prod_q;
`else
    assign prod_adj = is_w(op_q) ? (prod_q >> (XLEN - 32)) : prod_q;
`endif

    always_comb begin
        div_mag = is_rem(op_q) ? div_rem : div_quot;
        div_res = res_neg_q ? -div_mag : div_mag;
        prod_s  = res_neg_q ? -prod_adj : prod_adj;
        if (special_q)          raw_res = spec_res_q;
        else if (is_div(op_q))  raw_res = div_res;
        else if (is_high(op_q)) raw_res = prod_s[2*XLEN-1:XLEN];
        else                    raw_res = prod_s[XLEN-1:0];
    end

    assign done_o      = (state_q == ST_DONE);
    assign result_o    = done_o ? (is_w(op_q) ? ext32(raw_res, 1'b1) : raw_res) : '0;
    assign stall_req_o = valid_i & ~rst & (state_q != ST_DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=64) using an expected-result queue.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int XLEN = 64;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
    localparam logic [3:0] RST_OP = OP_DIV;
`else
    localparam bit FAST = 1'b0;
    localparam logic [3:0] RST_OP = OP_MUL;
`endif
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_i = 1'b0;
    logic [3:0]      op_i = 4'd0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic            ex_stall_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            stall_req_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .ex_stall_i  (ex_stall_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference results computed with wide native arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  wa, wb;
        logic signed [127:0] ps;
        logic [127:0]        pu;
        logic [31:0]         ua, ub, t32;
        logic                ov64, ov32;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        ov64 = (a == MIN64) && (b == ONES);
        ov32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return ps[127:64]; end
            OP_MULHSU: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); return ps[127:64]; end
            OP_MULHU:  begin pu = {64'b0, a} * {64'b0, b}; return pu[127:64]; end
            OP_DIV:    begin if (b == 0) return ONES; if (ov64) return MIN64; return sa / sb; end
            OP_DIVU:   begin if (b == 0) return ONES; return a / b; end
            OP_REM:    begin if (b == 0) return a; if (ov64) return 64'd0; return sa % sb; end
            OP_REMU:   begin if (b == 0) return a; return a % b; end
            OP_MULW:   begin t32 = ua * ub; return sx32(t32); end
            OP_DIVW:   begin if (ub == 0) return ONES; if (ov32) return sx32(32'h8000_0000);
                             t32 = wa / wb; return sx32(t32); end
            OP_DIVUW:  begin if (ub == 0) return ONES; t32 = ua / ub; return sx32(t32); end
            OP_REMW:   begin if (ub == 0) return sx32(ua); if (ov32) return 64'd0;
                             t32 = wa % wb; return sx32(t32); end
            OP_REMUW:  begin if (ub == 0) return sx32(ua); t32 = ua % ub; return sx32(t32); end
            default:   return 64'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, dv;
        w  = (op >= OP_MULW);
        dv = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        if (!dv) return FAST ? 1 : (w ? 33 : 65);
        if (w) begin
            if (b[31:0] == 32'd0) return 1;
            if ((op == OP_DIVW || op == OP_REMW) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                return 1;
            return 33;
        end
        if (b == 64'd0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == MIN64 && b == ONES) return 1;
        return 65;
    endfunction

    // Entered and left at posedge+1.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int hold, input bit keep);
        int lat, stall_n, want;
        bit rose;
        want = exp_lat(op, a, b);
        op_i = op; rs1_i = a; rs2_i = b; valid_i = 1'b1;
        exp_q.push_back(exp);
        #1;
        chk("stall_c0", 64'(stall_req_o), 64'd1);
        lat = 0; stall_n = 0;
        while (!done_o && lat < 200) begin
            if (stall_req_o) stall_n++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(want));
        chk("stall_cycles", 64'(stall_n), 64'(want));
        chk("stall_in_done", 64'(stall_req_o), 64'd0);
        chk("result", result_o, exp_q.pop_front());
        $display("op=%0d rs1=%h rs2=%h result=%h latency=%0d", op, a, b, result_o, lat);
        if (hold > 0) begin
            ex_stall_i = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_done", 64'(done_o), 64'd1);
                chk("hold_result", result_o, exp);
            end
            ex_stall_i = 1'b0;
        end
        @(posedge clk); #1;
        chk("done_fall", 64'(done_o), 64'd0);
        if (keep) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            rose = 1'b0;
            repeat (70) begin
                if (done_o) rose = 1'b1;
                @(posedge clk); #1;
            end
            chk("no_reexec", 64'(rose), 64'd0);
        end else begin
            valid_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0]  rop;
        logic [63:0] ra, rb;
        bit          rose;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(stall_req_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 64'(done_o), 64'd0);

        // Directed cases
        run_op(OP_DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 0, 1'b0);
        run_op(OP_REM,   MIN64, ONES, 64'd0, 0, 1'b0);
        run_op(OP_DIVU,  64'd5, 64'd0, ONES, 0, 1'b0);
        run_op(OP_MULH,  ONES, ONES, 64'd0, 0, 1'b0);
        run_op(OP_MULHU, ONES, 64'd2, 64'd1, 0, 1'b0);
        run_op(OP_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0);
        run_op(OP_DIVW,  64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0, 1'b0);

        // Flush at cycle 20 of a divide, new op two cycles later
        op_i = OP_DIV; rs1_i = 64'd1000; rs2_i = 64'd3; valid_i = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        rose = 1'b0;
        repeat (2) begin
            if (done_o) rose = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush20_no_done", 64'(rose), 64'd0);
        run_op(OP_DIVU, 64'd1000, 64'd7, 64'd142, 0, 1'b0);

        // Flush coinciding with entry to DONE
        op_i = OP_DIV; rs1_i = 64'd77; rs2_i = 64'd5; valid_i = 1'b1;
        repeat (64) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_at_done", 64'(done_o), 64'd0);
        @(posedge clk); #1;
        chk("flush_at_done_later", 64'(done_o), 64'd0);

        // Held in DONE by ex_stall_i, then no re-execution of the held op
        run_op(OP_REMU, 64'd1234567, 64'd1000, 64'd567, 5, 1'b1);

        // Reset mid-operation
        op_i = RST_OP; rs1_i = 64'd12345; rs2_i = 64'd678; valid_i = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1; valid_i = 1'b0;
        #1;
        chk("midrst_stall", 64'(stall_req_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(OP_MUL, 64'd12345, 64'd678, 64'd8369910, 0, 1'b0);

        // Randomised ops against the reference model
        for (int i = 0; i < 14; i++) begin
            rop = 4'($urandom_range(0, 12));
            ra  = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(1, 50000));
            else                           rb = {$urandom, $urandom};
            run_op(rop, ra, rb, model(rop, ra, rb), 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
